// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode with a 2-entry skid buffer and flush
module decode_stage #(
  parameter int XLEN   = 32,
  parameter int ALU_W  = 4,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_insn,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [REG_AW-1:0] out_rs1,
  output logic [REG_AW-1:0] out_rs2,
  output logic [REG_AW-1:0] out_rd,
  output logic [XLEN-1:0]   out_imm,
  output logic              out_reg_we,
  output logic              out_mem_re,
  output logic              out_mem_we,
  output logic              out_branch,
  output logic              out_jump,
  output logic              out_alu_src_imm,
  output logic [ALU_W-1:0]  out_alu_ctr,
  output logic              out_illegal
);
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [XLEN-1:0]   imm;
    logic              reg_we, mem_re, mem_we, branch, jump, src;
    logic [ALU_W-1:0]  alu;
    logic              illegal;
  } bundle_t;
  localparam logic [ALU_W-1:0] alu_and = 0, alu_or = 1, alu_add = 2, alu_sub = 3, alu_xor = 4,
                               alu_slt = 5, alu_sll = 6, alu_srl = 7, alu_sra = 8;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  logic [ALU_W-1:0] alu_f3;
  logic ok, drain, accept, m_v, s_v;
  bundle_t d, m, s;
  assign op = in_insn[6:0];
  assign f3 = in_insn[14:12];
  assign f7 = in_insn[31:25];
  assign imm_i = {{20{in_insn[31]}}, in_insn[31:20]};
  assign imm_s = {{20{in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
  assign imm_b = {{19{in_insn[31]}}, in_insn[31], in_insn[7], in_insn[30:25], in_insn[11:8], 1'b0};
  assign imm_u = {in_insn[31:12], 12'b0};
  assign imm_j = {{11{in_insn[31]}}, in_insn[31], in_insn[19:12], in_insn[20], in_insn[30:21], 1'b0};
  // insn[30] selects SRA over SRL for both register and immediate shifts
  assign alu_f3 = f3 == 3'b111 ? alu_and : f3 == 3'b110 ? alu_or : f3 == 3'b100 ? alu_xor :
                  f3 == 3'b010 ? alu_slt : f3 == 3'b001 ? alu_sll :
                  f3 == 3'b101 ? (in_insn[30] ? alu_sra : alu_srl) : alu_add;
  always_comb begin
    d = '0;
    ok = 1'b0;
    imm32 = '0;
    d.pc = in_pc;
    d.rs1 = REG_AW'(in_insn[19:15]);
    d.rs2 = REG_AW'(in_insn[24:20]);
    d.rd = REG_AW'(in_insn[11:7]);
    case (op)
      7'b0000011: begin ok = f3 == 3'b010; imm32 = imm_i; d.reg_we = 1'b1; d.mem_re = 1'b1; d.src = 1'b1; d.alu = alu_add; end
      7'b0100011: begin ok = f3 == 3'b010; imm32 = imm_s; d.mem_we = 1'b1; d.src = 1'b1; d.alu = alu_add; end
      7'b0110011: begin
        ok = f7 == 7'b0 ? f3 != 3'b011 : f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101);
        d.reg_we = 1'b1;
        d.alu = (f3 == 3'b000 && f7[5]) ? alu_sub : alu_f3;
      end
      7'b0010011: begin
        ok = f3 == 3'b001 ? f7 == 7'b0 : f3 == 3'b101 ? (f7 == 7'b0 || f7 == 7'b0100000) : f3 != 3'b011;
        imm32 = imm_i; d.reg_we = 1'b1; d.src = 1'b1; d.alu = alu_f3;
      end
      7'b1100011: begin ok = f3[2:1] == 2'b00; imm32 = imm_b; d.branch = 1'b1; d.alu = alu_sub; end
      7'b1101111: begin ok = 1'b1; imm32 = imm_j; d.jump = 1'b1; d.reg_we = 1'b1; d.alu = alu_add; end
      7'b0110111: begin ok = 1'b1; imm32 = imm_u; d.rs1 = '0; d.reg_we = 1'b1; d.src = 1'b1; d.alu = alu_add; end
      default: ok = 1'b0;
    endcase
    d.imm = XLEN'($signed(imm32));
    if (!ok) begin
      d.imm = '0;
      d.reg_we = 1'b0;
      d.mem_re = 1'b0;
      d.mem_we = 1'b0;
      d.branch = 1'b0;
      d.jump = 1'b0;
      d.src = 1'b0;
      d.alu = alu_and;
    end
    d.reg_we = d.reg_we & (d.rd != '0);
    d.illegal = !ok;
  end
  assign in_ready = !s_v;
  assign drain = m_v & out_ready;
  assign accept = in_valid & in_ready & !flush;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
      m <= '0;
      s <= '0;
    end else if (flush) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
    end else if (!m_v || drain) begin
      if (s_v) begin
        m <= s;
        m_v <= 1'b1;
        s_v <= 1'b0;
      end else begin
        m_v <= accept;
        if (accept) m <= d;
      end
    end else if (accept) begin
      s <= d;
      s_v <= 1'b1;
    end
  assign out_valid = m_v;
  assign out_pc = m.pc;
  assign out_rs1 = m.rs1;
  assign out_rs2 = m.rs2;
  assign out_rd = m.rd;
  assign out_imm = m.imm;
  assign out_reg_we = m.reg_we;
  assign out_mem_re = m.mem_re;
  assign out_mem_we = m.mem_we;
  assign out_branch = m.branch;
  assign out_jump = m.jump;
  assign out_alu_src_imm = m.src;
  assign out_alu_ctr = m.alu;
  assign out_illegal = m.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors through a queue scoreboard checked by a monitor
module tb_decode_stage;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [5:0]  fl;
    logic [3:0]  alu;
    logic        ill;
  } b_t;
  logic clk = 0, rst_n = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_insn = 0, in_pc = 0;
  logic in_ready, out_valid, out_reg_we, out_mem_re, out_mem_we, out_branch, out_jump, out_alu_src_imm, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [4:0] out_rs1, out_rs2, out_rd;
  logic [3:0] out_alu_ctr;
  b_t got, held, e_m;
  b_t expq[$];
  b_t ev[13];
  logic [31:0] iv[13];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_insn(in_insn), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_reg_we(out_reg_we), .out_mem_re(out_mem_re), .out_mem_we(out_mem_we),
    .out_branch(out_branch), .out_jump(out_jump), .out_alu_src_imm(out_alu_src_imm),
    .out_alu_ctr(out_alu_ctr), .out_illegal(out_illegal)
  );
  assign got = {out_pc, out_rs1, out_rs2, out_rd, out_imm, out_reg_we, out_mem_re, out_mem_we,
                out_branch, out_jump, out_alu_src_imm, out_alu_ctr, out_illegal};
  task automatic chk1(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, a, e);
    end
  endtask
  task automatic chkb(input string n, input b_t a, input b_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic push(input int k);
    bit acc = 0;
    in_insn = iv[k];
    in_pc = ev[k].pc;
    in_valid = 1;
    for (int n = 0; n < 40 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    if (acc) expq.push_back(ev[k]);
    else begin
      checks++;
      errors++;
      $display("FAIL accept timeout: insn %h not taken, expected acceptance within 40 cycles", iv[k]);
    end
  endtask
  always @(negedge clk)
    if (rst_n && out_valid && out_ready && !flush) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected bundle: got %h expected none", got);
      end else begin
        e_m = expq.pop_front();
        chkb("bundle", got, e_m);
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1, "watchdog");
  end
  initial begin
    iv[0]  = 32'h002081B3; ev[0]  = '{32'h100, 5'd1,  5'd2,  5'd3,  32'h0,        6'b100000, 4'd2, 1'b0};
    iv[1]  = 32'hFFC12283; ev[1]  = '{32'h104, 5'd2,  5'd28, 5'd5,  32'hFFFFFFFC, 6'b110001, 4'd2, 1'b0};
    iv[2]  = 32'h0060A423; ev[2]  = '{32'h108, 5'd1,  5'd6,  5'd8,  32'h8,        6'b001001, 4'd2, 1'b0};
    iv[3]  = 32'hFFFFFFFF; ev[3]  = '{32'h10C, 5'd31, 5'd31, 5'd31, 32'h0,        6'b000000, 4'd0, 1'b1};
    iv[4]  = 32'h00208033; ev[4]  = '{32'h110, 5'd1,  5'd2,  5'd0,  32'h0,        6'b000000, 4'd2, 1'b0};
    iv[5]  = 32'h403100B3; ev[5]  = '{32'h114, 5'd2,  5'd3,  5'd1,  32'h0,        6'b100000, 4'd3, 1'b0};
    iv[6]  = 32'h4032D213; ev[6]  = '{32'h118, 5'd5,  5'd3,  5'd4,  32'h403,      6'b100001, 4'd8, 1'b0};
    iv[7]  = 32'hFFF00393; ev[7]  = '{32'h11C, 5'd0,  5'd31, 5'd7,  32'hFFFFFFFF, 6'b100001, 4'd2, 1'b0};
    iv[8]  = 32'hFE208CE3; ev[8]  = '{32'h120, 5'd1,  5'd2,  5'd25, 32'hFFFFFFF8, 6'b000100, 4'd3, 1'b0};
    iv[9]  = 32'h010000EF; ev[9]  = '{32'h124, 5'd0,  5'd16, 5'd1,  32'h10,       6'b100010, 4'd2, 1'b0};
    iv[10] = 32'h12345537; ev[10] = '{32'h128, 5'd0,  5'd3,  5'd10, 32'h12345000, 6'b100001, 4'd2, 1'b0};
    iv[11] = 32'h02000033; ev[11] = '{32'h12C, 5'd0,  5'd0,  5'd0,  32'h0,        6'b000000, 4'd0, 1'b1};
    iv[12] = 32'h0041A133; ev[12] = '{32'h130, 5'd3,  5'd4,  5'd2,  32'h0,        6'b100000, 4'd5, 1'b0};
    #1 rst_n = 0;
    #1;
    chk1("reset out_valid", out_valid, 0);
    chk1("reset in_ready", in_ready, 1);
    chkb("reset bundle", got, '0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1 out_ready = 1;
    push(0);
    chk1("one-cycle latency", out_valid, 1);
    for (int k = 1; k < 13; k++) push(k);
    repeat (3) @(posedge clk);
    #1 out_ready = 0;
    push(1);
    push(2);
    chk1("in_ready low with skid full", in_ready, 0);
    fork
      push(8);
      begin
        held = got;
        repeat (2) begin
          @(negedge clk);
          chkb("stall stable", got, held);
        end
        @(posedge clk);
        #1 out_ready = 1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk1("back-to-back drain", out_valid, 1);
        end
      end
    join
    repeat (3) @(posedge clk);
    #1 out_ready = 0;
    push(9);
    push(10);
    in_insn = iv[11];
    in_pc = ev[11].pc;
    in_valid = 1;
    flush = 1;
    @(posedge clk);
    #1 flush = 0;
    in_valid = 0;
    expq.delete();
    chk1("flush out_valid", out_valid, 0);
    chk1("flush in_ready", in_ready, 1);
    out_ready = 1;
    repeat (3) @(posedge clk);
    #1 chk1("flushed input absent", out_valid, 0);
    push(12);
    repeat (3) @(posedge clk);
    #1 out_ready = 0;
    push(0);
    @(negedge clk);
    chk1("stalled before reset", out_valid, 1);
    #2 rst_n = 0;
    #1;
    chk1("async reset out_valid", out_valid, 0);
    chk1("async reset in_ready", in_ready, 1);
    chkb("async reset bundle", got, '0);
    expq.delete();
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1 out_ready = 1;
    push(5);
    repeat (3) @(posedge clk);
    #1 chk1("scoreboard drained", expq.size() == 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
